// File: rtl/adder_var_comb.sv
`default_nettype none
// ============================================================================
// Module      : adder_var_comb
// Description : Two-operand unsigned adder with per-operand valid
//               qualification and a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_var_comb #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    input  logic                      i_en,
    output logic                      o_valid,
    output logic [DATA_WIDTH:0]       o_data_bus
);

    localparam int c_OUT_WIDTH = DATA_WIDTH + 1;

    logic [c_OUT_WIDTH-1:0] w_data_a;
    logic [c_OUT_WIDTH-1:0] w_data_b;
    logic                   w_next_valid;
    logic [c_OUT_WIDTH-1:0] w_next_data;

    logic                   r_valid;
    logic [c_OUT_WIDTH-1:0] r_data;

    // Operands are zero-extended first so the carry of a full add lands in the MSB.
    assign w_data_a = {1'b0, i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign w_data_b = {1'b0, i_data_bus[DATA_WIDTH-1:0]};

    always_comb begin
        w_next_valid = 1'b0;
        w_next_data  = '0;
        if (i_en) begin
            unique case (i_valid)
                2'b11: begin
                    w_next_valid = 1'b1;
                    w_next_data  = w_data_a + w_data_b;
                end
                2'b10: begin
                    w_next_valid = 1'b1;
                    w_next_data  = w_data_a;
                end
                2'b01: begin
                    w_next_valid = 1'b1;
                    w_next_data  = w_data_b;
                end
                default: begin
                    w_next_valid = 1'b0;
                    w_next_data  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_next_valid;
            r_data  <= w_next_data;
        end
    end

    assign o_valid    = r_valid;
    assign o_data_bus = r_data;

endmodule
`default_nettype wire

// File: tb/tb_adder_var_comb.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_var_comb
// Description : Scoreboard bench for adder_var_comb with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_var_comb;

    localparam int DATA_WIDTH = 4;

    typedef struct {
        logic       exp_valid;
        logic [4:0] exp_data;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] i_valid;
    logic [7:0] i_data_bus;
    logic       i_en;
    logic       o_valid;
    logic [4:0] o_data_bus;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    adder_var_comb #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected result belongs to the next rising edge.
    task automatic drive(input logic r, input logic en, input logic [1:0] v,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic ev, input logic [4:0] ed, input string nm);
        exp_t e;
        @(negedge clk);
        rst        = r;
        i_en       = en;
        i_valid    = v;
        i_data_bus = {a, b};
        e.exp_valid = ev;
        e.exp_data  = ed;
        e.name      = nm;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_valid !== e.exp_valid || o_data_bus !== e.exp_data) begin
                    failures++;
                    $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h",
                             e.name, o_valid, o_data_bus, e.exp_valid, e.exp_data);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        i_en       = 1'b0;
        i_valid    = 2'b00;
        i_data_bus = '0;

        drive(1, 1, 2'b11, 4'hF, 4'hE, 0, 5'h00, "reset_0");
        drive(1, 1, 2'b11, 4'hF, 4'hE, 0, 5'h00, "reset_1");
        drive(0, 0, 2'b11, 4'h0, 4'h1, 0, 5'h00, "disabled");
        drive(0, 1, 2'b11, 4'hF, 4'h0, 1, 5'h0F, "add_no_carry");
        drive(0, 1, 2'b11, 4'hF, 4'hE, 1, 5'h1D, "add_carry");
        drive(0, 1, 2'b01, 4'hF, 4'hE, 1, 5'h0E, "pass_b");
        drive(0, 1, 2'b10, 4'hF, 4'hE, 1, 5'h0F, "pass_a");
        drive(0, 1, 2'b00, 4'hA, 4'h7, 0, 5'h00, "none_valid");
        drive(0, 1, 2'b11, 4'hE, 4'h5, 1, 5'h13, "add_e_5");
        drive(0, 1, 2'b11, 4'hF, 4'hF, 1, 5'h1E, "stream_ff");
        drive(0, 1, 2'b11, 4'h1, 4'h1, 1, 5'h02, "stream_11");
        drive(0, 1, 2'b11, 4'h0, 4'h0, 1, 5'h00, "stream_00");
        drive(0, 1, 2'b11, 4'hF, 4'hF, 1, 5'h1E, "stream2_ff");
        drive(1, 1, 2'b11, 4'h1, 4'h1, 0, 5'h00, "stream2_rst");
        drive(0, 1, 2'b11, 4'h7, 4'h9, 1, 5'h10, "stream2_resume");
        drive(0, 1, 2'b01, 4'hF, 4'h0, 1, 5'h00, "pass_b_zero");
        drive(0, 1, 2'b10, 4'h3, 4'hC, 1, 5'h03, "pass_a_small");
        drive(0, 0, 2'b00, 4'h0, 4'h0, 0, 5'h00, "idle");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
